// File: rtl/ddr_line_fetch.sv
// ddr_line_fetch: sequences DDR read bursts that fill the back bank of a
// double-banked scanline buffer and owns the framebuffer line pointer.
//
// Ports:
//   i_clk            system clock
//   i_reset          asynchronous active-low reset
//   i_frame_start    vblank pulse, rewinds the line pointer
//   i_line_req       request to fetch the next line into the back bank
//   i_ddr_busy       DDR waitrequest
//   o_ddr_rd         DDR read request
//   o_ddr_addr       burst start word address
//   o_ddr_burstcnt   burst length (constant BURST_LEN)
//   i_ddr_dout       DDR read data
//   i_ddr_dout_ready DDR read data valid
//   o_buf_we         line-buffer write strobe
//   o_buf_addr       line-buffer address {bank, word index}
//   o_buf_data       line-buffer write data
//   o_disp_bank      bank read by the display side
//   o_line_done      one-cycle pulse when a line is fully written
//   o_busy           fetch in progress
//   o_underrun       sticky: line request seen while busy
module ddr_line_fetch #(
  parameter logic [28:0] FB_BASE    = 29'h0600_0000,
  parameter int unsigned LINE_WORDS = 64,
  parameter int unsigned BURST_LEN  = 8,
  localparam int unsigned AW        = $clog2(LINE_WORDS) + 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_frame_start,
  input  logic          i_line_req,
  input  logic          i_ddr_busy,
  output logic          o_ddr_rd,
  output logic [28:0]   o_ddr_addr,
  output logic [7:0]    o_ddr_burstcnt,
  input  logic [63:0]   i_ddr_dout,
  input  logic          i_ddr_dout_ready,
  output logic          o_buf_we,
  output logic [AW-1:0] o_buf_addr,
  output logic [63:0]   o_buf_data,
  output logic          o_disp_bank,
  output logic          o_line_done,
  output logic          o_busy,
  output logic          o_underrun
);

  localparam int unsigned IW = $clog2(LINE_WORDS);
  localparam int unsigned BW = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0] BurstLast = BW'(BURST_LEN - 1);
  localparam logic [IW-1:0] WordLast  = IW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e          r_state, w_state_d;
  logic [28:0]     r_line_ptr, w_line_ptr_d;
  logic [IW-1:0]   r_widx, w_widx_d;
  logic [BW-1:0]   r_bcnt, w_bcnt_d;
  logic            r_fetch_bank, w_fetch_bank_d;
  logic            r_pend, w_pend_d;
  logic            r_ddr_rd, w_ddr_rd_d;
  logic [28:0]     r_ddr_addr, w_ddr_addr_d;
  logic            r_buf_we, w_buf_we_d;
  logic [AW-1:0]   r_buf_addr, w_buf_addr_d;
  logic [63:0]     r_buf_data, w_buf_data_d;
  logic            r_disp, w_disp_d;
  logic            r_done, w_done_d;
  logic            r_busy, w_busy_d;
  logic            r_underrun, w_underrun_d;

  always_comb begin
    w_state_d      = r_state;
    w_line_ptr_d   = r_line_ptr;
    w_widx_d       = r_widx;
    w_bcnt_d       = r_bcnt;
    w_fetch_bank_d = r_fetch_bank;
    w_pend_d       = r_pend;
    w_ddr_rd_d     = r_ddr_rd;
    w_ddr_addr_d   = r_ddr_addr;
    w_buf_we_d     = 1'b0;
    w_buf_addr_d   = r_buf_addr;
    w_buf_data_d   = r_buf_data;
    w_disp_d       = r_disp;
    w_done_d       = 1'b0;
    w_underrun_d   = r_underrun;

    unique case (r_state)
      StIdle: begin
        if (i_frame_start) begin
          w_line_ptr_d = FB_BASE;
          w_disp_d     = 1'b0;
          w_underrun_d = 1'b0;
        end
        if (i_line_req) begin
          // A simultaneous rewind takes effect first, so use the rewound view.
          w_state_d      = StIssue;
          w_widx_d       = '0;
          w_bcnt_d       = '0;
          w_fetch_bank_d = i_frame_start ? 1'b1 : ~r_disp;
          w_ddr_rd_d     = 1'b1;
          w_ddr_addr_d   = i_frame_start ? FB_BASE : r_line_ptr;
        end
      end
      StIssue: begin
        if (!i_ddr_busy) begin
          w_ddr_rd_d = 1'b0;
          w_state_d  = StWait;
        end
      end
      StWait: begin
        if (i_ddr_dout_ready) begin
          w_buf_we_d   = 1'b1;
          w_buf_data_d = i_ddr_dout;
          w_buf_addr_d = {r_fetch_bank, r_widx};
          w_widx_d     = r_widx + IW'(1);
          w_bcnt_d     = r_bcnt + BW'(1);
          if (r_bcnt == BurstLast) begin
            w_bcnt_d = '0;
            if (r_widx == WordLast) begin
              w_state_d = StDone;
            end else begin
              w_state_d    = StIssue;
              w_ddr_rd_d   = 1'b1;
              w_ddr_addr_d = r_line_ptr + 29'(r_widx) + 29'd1;
            end
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
        w_done_d  = 1'b1;
        // A rewind requested during the fetch replaces this line's increment.
        if (r_pend || i_frame_start) begin
          w_line_ptr_d = FB_BASE;
          w_disp_d     = 1'b0;
          w_underrun_d = 1'b0;
          w_pend_d     = 1'b0;
        end else begin
          w_line_ptr_d = r_line_ptr + 29'(LINE_WORDS);
          w_disp_d     = ~r_disp;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (i_frame_start && (r_state == StIssue || r_state == StWait)) begin
      w_pend_d = 1'b1;
    end
    if (i_line_req && r_state != StIdle) begin
      w_underrun_d = 1'b1;
    end

    // Busy stays up through the line_done cycle.
    w_busy_d = (w_state_d != StIdle) || (r_state == StDone);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= StIdle;
      r_line_ptr   <= FB_BASE;
      r_widx       <= '0;
      r_bcnt       <= '0;
      r_fetch_bank <= 1'b0;
      r_pend       <= 1'b0;
      r_ddr_rd     <= 1'b0;
      r_ddr_addr   <= '0;
      r_buf_we     <= 1'b0;
      r_buf_addr   <= '0;
      r_buf_data   <= '0;
      r_disp       <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_line_ptr   <= w_line_ptr_d;
      r_widx       <= w_widx_d;
      r_bcnt       <= w_bcnt_d;
      r_fetch_bank <= w_fetch_bank_d;
      r_pend       <= w_pend_d;
      r_ddr_rd     <= w_ddr_rd_d;
      r_ddr_addr   <= w_ddr_addr_d;
      r_buf_we     <= w_buf_we_d;
      r_buf_addr   <= w_buf_addr_d;
      r_buf_data   <= w_buf_data_d;
      r_disp       <= w_disp_d;
      r_done       <= w_done_d;
      r_busy       <= w_busy_d;
      r_underrun   <= w_underrun_d;
    end
  end

  assign o_ddr_rd       = r_ddr_rd;
  assign o_ddr_addr     = r_ddr_addr;
  assign o_ddr_burstcnt = 8'(BURST_LEN);
  assign o_buf_we       = r_buf_we;
  assign o_buf_addr     = r_buf_addr;
  assign o_buf_data     = r_buf_data;
  assign o_disp_bank    = r_disp;
  assign o_line_done    = r_done;
  assign o_busy         = r_busy;
  assign o_underrun     = r_underrun;

endmodule

// File: tb/tb_ddr_line_fetch.sv
// tb_ddr_line_fetch: scoreboard bench for ddr_line_fetch. Expected bursts and
// buffer writes are queued when a line request is driven; a DDR responder and
// a buffer-write monitor pop and compare them as the DUT produces them.
module tb_ddr_line_fetch;

  localparam logic [28:0] FB = 29'h0600_0000;
  localparam int LW = 64;
  localparam int BL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start, line_req, ddr_busy;
  logic        ddr_rd;
  logic [28:0] ddr_addr;
  logic [7:0]  ddr_burstcnt;
  logic [63:0] ddr_dout;
  logic        ddr_dout_ready;
  logic        buf_we;
  logic [6:0]  buf_addr;
  logic [63:0] buf_data;
  logic        disp_bank, line_done, busy, underrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [28:0] exp_burst_q[$];
  logic [70:0] exp_wr_q[$];

  // Responder state.
  int          words_left = 0;
  int          wd_idx = 0;
  logic [28:0] rd_base = '0;
  bit          in_req = 0;
  int          req_ord = 0;
  int          stall_at = 0;
  int          stall_left = 0;
  int          burst_seen = 0;
  int          wr_seen = 0;

  // Bench model of line pointer and display bank.
  logic [28:0] exp_ptr = FB;
  logic        exp_disp = 1'b0;

  ddr_line_fetch #(
    .FB_BASE   (FB),
    .LINE_WORDS(LW),
    .BURST_LEN (BL)
  ) u_dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_frame_start   (frame_start),
    .i_line_req      (line_req),
    .i_ddr_busy      (ddr_busy),
    .o_ddr_rd        (ddr_rd),
    .o_ddr_addr      (ddr_addr),
    .o_ddr_burstcnt  (ddr_burstcnt),
    .i_ddr_dout      (ddr_dout),
    .i_ddr_dout_ready(ddr_dout_ready),
    .o_buf_we        (buf_we),
    .o_buf_addr      (buf_addr),
    .o_buf_data      (buf_data),
    .o_disp_bank     (disp_bank),
    .o_line_done     (line_done),
    .o_busy          (busy),
    .o_underrun      (underrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input logic [28:0] a);
    return {3'b101, a, 3'b010, a};
  endfunction

  // DDR responder: accepts one burst at a time, optional waitrequest stall,
  // returns BL words on consecutive cycles starting the cycle after acceptance.
  initial begin
    ddr_busy       = 1'b0;
    ddr_dout_ready = 1'b0;
    ddr_dout       = '0;
    forever begin
      @(negedge clk);
      if (words_left > 0) begin
        ddr_dout_ready = 1'b1;
        ddr_dout       = word_of(rd_base + 29'(wd_idx));
        wd_idx++;
        words_left--;
      end else begin
        ddr_dout_ready = 1'b0;
        ddr_dout       = '0;
      end
      ddr_busy = 1'b0;
      if (ddr_rd === 1'b1 && words_left == 0) begin
        if (!in_req) begin
          in_req = 1;
          req_ord++;
          if (req_ord == stall_at) stall_left = 5;
        end
        if (stall_left > 0) begin
          ddr_busy = 1'b1;
          stall_left--;
          if (exp_burst_q.size() > 0)
            check_eq("hold_addr", 64'(ddr_addr), 64'(exp_burst_q[0]));
        end else begin
          in_req = 0;
          if (exp_burst_q.size() == 0) check_eq("extra_burst", 64'd1, 64'd0);
          else check_eq("burst_addr", 64'(ddr_addr), 64'(exp_burst_q.pop_front()));
          check_eq("burstcnt", 64'(ddr_burstcnt), 64'(BL));
          burst_seen++;
          rd_base    = ddr_addr;
          wd_idx     = 0;
          words_left = BL;
        end
      end else if (in_req) begin
        check_eq("rd_held", 64'(ddr_rd), 64'd1);
        in_req = 0;
      end
    end
  end

  // Buffer-write monitor.
  initial begin : mon
    logic [70:0] e;
    forever begin
      @(negedge clk);
      if (buf_we === 1'b1) begin
        if (exp_wr_q.size() == 0) begin
          check_eq("unexpected_we", 64'd1, 64'd0);
        end else begin
          e = exp_wr_q.pop_front();
          check_eq("buf_addr", 64'(buf_addr), 64'(e[70:64]));
          check_eq("buf_data", buf_data, e[63:0]);
        end
        wr_seen++;
      end
    end
  end

  task automatic check_reset_vals();
    check_eq("rst_ddr_rd", 64'(ddr_rd), 64'd0);
    check_eq("rst_ddr_addr", 64'(ddr_addr), 64'd0);
    check_eq("rst_burstcnt", 64'(ddr_burstcnt), 64'(BL));
    check_eq("rst_buf_we", 64'(buf_we), 64'd0);
    check_eq("rst_buf_addr", 64'(buf_addr), 64'd0);
    check_eq("rst_buf_data", buf_data, 64'd0);
    check_eq("rst_disp_bank", 64'(disp_bank), 64'd0);
    check_eq("rst_line_done", 64'(line_done), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_underrun", 64'(underrun), 64'd0);
  endtask

  task automatic push_line(input logic [28:0] base, input logic bank);
    for (int b = 0; b < LW / BL; b++) exp_burst_q.push_back(base + 29'(b * BL));
    for (int w = 0; w < LW; w++) exp_wr_q.push_back({bank, 6'(w), word_of(base + 29'(w))});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_vals();
    exp_burst_q.delete();
    exp_wr_q.delete();
    exp_ptr  = FB;
    exp_disp = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_line(input int stall, input bit mid_req, input bit mid_fs, input bit with_fs);
    logic [28:0] base;
    logic        bank;
    bit          seen;
    if (with_fs) begin
      exp_ptr  = FB;
      exp_disp = 1'b0;
    end
    base = exp_ptr;
    bank = ~exp_disp;
    push_line(base, bank);
    burst_seen = 0;
    wr_seen    = 0;
    req_ord    = 0;
    stall_at   = stall;
    @(negedge clk);
    line_req    = 1'b1;
    frame_start = with_fs;
    @(negedge clk);
    line_req    = 1'b0;
    frame_start = 1'b0;
    check_eq("rd_latency", 64'(ddr_rd), 64'd1);
    check_eq("busy_on", 64'(busy), 64'd1);
    seen = 0;
    for (int cyc = 0; cyc < 600 && !seen; cyc++) begin
      @(negedge clk);
      line_req    = 1'b0;
      frame_start = 1'b0;
      if (line_done === 1'b1) begin
        seen = 1;
      end else if (cyc == 20) begin
        line_req    = mid_req;
        frame_start = mid_fs;
      end
      if (cyc == 21 && mid_req) check_eq("underrun_set", 64'(underrun), 64'd1);
    end
    if (!seen) begin
      check_eq("done_timeout", 64'd0, 64'd1);
    end else begin
      check_eq("writes_at_done", 64'(wr_seen), 64'(LW));
      check_eq("busy_at_done", 64'(busy), 64'd1);
      if (!mid_fs) check_eq("disp_at_done", 64'(disp_bank), 64'(bank));
      @(negedge clk);
      check_eq("busy_off", 64'(busy), 64'd0);
      check_eq("done_pulse", 64'(line_done), 64'd0);
      check_eq("disp_after", 64'(disp_bank), mid_fs ? 64'd0 : 64'(bank));
    end
    check_eq("burst_count", 64'(burst_seen), 64'(LW / BL));
    check_eq("bursts_left", 64'(exp_burst_q.size()), 64'd0);
    check_eq("writes_left", 64'(exp_wr_q.size()), 64'd0);
    if (mid_fs) begin
      exp_ptr  = FB;
      exp_disp = 1'b0;
    end else begin
      exp_ptr  = base + 29'(LW);
      exp_disp = bank;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    frame_start = 1'b0;
    line_req    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Plain line, then a line with waitrequest held on the third burst.
    run_line(0, 0, 0, 0);
    pulse_reset();
    run_line(3, 0, 0, 0);

    // Second line into bank 0 with an underrun request mid-fetch.
    run_line(0, 1, 0, 0);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check_eq("underrun_clr", 64'(underrun), 64'd0);
    check_eq("disp_rewind", 64'(disp_bank), 64'd0);
    exp_ptr  = FB;
    exp_disp = 1'b0;

    // Three lines; rewind requested during the third, then fetch from base.
    run_line(0, 0, 0, 0);
    run_line(0, 0, 0, 0);
    run_line(0, 0, 1, 0);
    run_line(0, 0, 0, 0);

    // Reset during WAIT after three words; late data must be ignored.
    push_line(exp_ptr, ~exp_disp);
    wr_seen = 0;
    req_ord = 0;
    stall_at = 0;
    @(negedge clk);
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (wr_seen >= 3) break;
    end
    reset = 1'b0;
    check_eq("partial_writes", 64'(wr_seen), 64'd3);
    #1 check_reset_vals();
    exp_burst_q.delete();
    exp_wr_q.delete();
    exp_ptr  = FB;
    exp_disp = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("idle_after_rst", 64'(busy), 64'd0);
    run_line(0, 0, 0, 0);

    // Simultaneous frame_start and line_req in IDLE fetches from base.
    run_line(0, 0, 0, 1);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
